// File: rtl/debounce_sync4.sv
// Synchronises and debounces N_CH raw inputs into stable levels, edge pulses and sticky glitch flags.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES - 1 edges from the first sample to the stable_out change.
// Backpressure: none; free-running, en=0 freezes outputs and clears pending changes.
module debounce_sync4 #(
    parameter int N_CH            = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] raw_in,
    input  logic            en,
    input  logic            clr_glitch,
    output logic [N_CH-1:0] stable_out,
    output logic [N_CH-1:0] rise_pulse,
    output logic [N_CH-1:0] fall_pulse,
    output logic [N_CH-1:0] glitch_seen,
    output logic [N_CH-1:0] busy
);
    localparam int            CW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic {STABLE = 1'b0, CHECK = 1'b1} state_t;

    logic [N_CH-1:0] sync_r [SYNC_STAGES];
    logic [N_CH-1:0] sync_q;
    state_t          state_q [N_CH];
    state_t          state_d [N_CH];
    logic [CW-1:0]   cnt_q [N_CH];
    logic [CW-1:0]   cnt_d [N_CH];
    logic [N_CH-1:0] stable_d;
    logic [N_CH-1:0] rise_d;
    logic [N_CH-1:0] fall_d;
    logic [N_CH-1:0] glitch_set;
    logic [N_CH-1:0] accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= '0;
        end else begin
            sync_r[0] <= raw_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
        end
    end

    assign sync_q = sync_r[SYNC_STAGES-1];

    always_comb begin
        stable_d   = stable_out;
        rise_d     = '0;
        fall_d     = '0;
        glitch_set = '0;
        accept     = '0;
        for (int ch = 0; ch < N_CH; ch++) begin
            state_d[ch] = STABLE;
            cnt_d[ch]   = '0;
            if (en) begin
                case (state_q[ch])
                    STABLE: begin
                        if (sync_q[ch] != stable_out[ch]) begin
                            if (CNT_MAX == CNT_ONE) begin
                                accept[ch] = 1'b1;
                            end else begin
                                state_d[ch] = CHECK;
                                cnt_d[ch]   = CNT_ONE;
                            end
                        end
                    end
                    CHECK: begin
                        if (sync_q[ch] != stable_out[ch]) begin
                            // >= rather than == so an out-of-range count still resolves, never wraps
                            if (cnt_q[ch] + CNT_ONE >= CNT_MAX) begin
                                accept[ch] = 1'b1;
                            end else begin
                                state_d[ch] = CHECK;
                                cnt_d[ch]   = cnt_q[ch] + CNT_ONE;
                            end
                        end else begin
                            glitch_set[ch] = 1'b1;
                        end
                    end
                endcase
                if (accept[ch]) begin
                    stable_d[ch] = sync_q[ch];
                    rise_d[ch]   = sync_q[ch];
                    fall_d[ch]   = ~sync_q[ch];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_out  <= '0;
            rise_pulse  <= '0;
            fall_pulse  <= '0;
            glitch_seen <= '0;
            for (int ch = 0; ch < N_CH; ch++) begin
                state_q[ch] <= STABLE;
                cnt_q[ch]   <= '0;
            end
        end else begin
            stable_out  <= stable_d;
            rise_pulse  <= rise_d;
            fall_pulse  <= fall_d;
            // a bounce on the same edge as a clear must still be recorded
            glitch_seen <= (clr_glitch ? '0 : glitch_seen) | glitch_set;
            for (int ch = 0; ch < N_CH; ch++) begin
                state_q[ch] <= state_d[ch];
                cnt_q[ch]   <= cnt_d[ch];
            end
        end
    end

    always_comb begin
        busy = '0;
        for (int ch = 0; ch < N_CH; ch++) busy[ch] = (state_q[ch] == CHECK);
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_cnt_chk
        a_cnt_limit: assert property (@(posedge clk) disable iff (!rst_n) cnt_q[g] <= CNT_MAX);
    end

endmodule

// File: tb/tb_debounce_sync4.sv
// Bench for debounce_sync4: a DEBOUNCE_CYCLES=4 and a DEBOUNCE_CYCLES=1 instance share stimulus
// and are compared every cycle against a run-length reference model over a raw-sample log.
module tb_debounce_sync4;
    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       clr_glitch;
    logic [3:0] raw_in;
    logic [3:0] st [2];
    logic [3:0] ri [2];
    logic [3:0] fa [2];
    logic [3:0] gl [2];
    logic [3:0] bz [2];

    int total = 0;
    int bad   = 0;

    logic [3:0] rawlog [$];
    logic [3:0] m_st [2];
    logic [3:0] m_ri [2];
    logic [3:0] m_fa [2];
    logic [3:0] m_gl [2];
    logic [3:0] m_bz [2];
    int         run [2][4];

    always #5 clk = ~clk;

    debounce_sync4 #(.N_CH(4), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .raw_in(raw_in), .en(en), .clr_glitch(clr_glitch),
        .stable_out(st[0]), .rise_pulse(ri[0]), .fall_pulse(fa[0]),
        .glitch_seen(gl[0]), .busy(bz[0])
    );

    debounce_sync4 #(.N_CH(4), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .raw_in(raw_in), .en(en), .clr_glitch(clr_glitch),
        .stable_out(st[1]), .rise_pulse(ri[1]), .fall_pulse(fa[1]),
        .glitch_seen(gl[1]), .busy(bz[1])
    );

    function automatic int dcyc(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        rawlog.delete();
        for (int i = 0; i < 2; i++) begin
            m_st[i] = '0; m_ri[i] = '0; m_fa[i] = '0; m_gl[i] = '0; m_bz[i] = '0;
            for (int c = 0; c < 4; c++) run[i][c] = 0;
        end
    endtask

    // The level seen by the debouncer is the raw sample taken S edges earlier.
    task automatic model_edge();
        logic [3:0] s;
        logic       set;
        if (!rst_n) begin
            model_reset();
            return;
        end
        s = (rawlog.size() >= S) ? rawlog[rawlog.size() - S] : 4'h0;
        rawlog.push_back(raw_in);
        for (int i = 0; i < 2; i++) begin
            m_ri[i] = '0;
            m_fa[i] = '0;
            for (int c = 0; c < 4; c++) begin
                set = 1'b0;
                if (!en) begin
                    run[i][c] = 0;
                end else if (s[c] != m_st[i][c]) begin
                    run[i][c]++;
                    if (run[i][c] >= dcyc(i)) begin
                        m_st[i][c] = s[c];
                        m_ri[i][c] = s[c];
                        m_fa[i][c] = ~s[c];
                        run[i][c]  = 0;
                    end
                end else begin
                    set       = (run[i][c] > 0);
                    run[i][c] = 0;
                end
                m_bz[i][c] = (run[i][c] > 0);
                m_gl[i][c] = (clr_glitch ? 1'b0 : m_gl[i][c]) | set;
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("d%0d stable", dcyc(i)), st[i], m_st[i]);
            chk($sformatf("d%0d rise", dcyc(i)), ri[i], m_ri[i]);
            chk($sformatf("d%0d fall", dcyc(i)), fa[i], m_fa[i]);
            chk($sformatf("d%0d glitch", dcyc(i)), gl[i], m_gl[i]);
            chk($sformatf("d%0d busy", dcyc(i)), bz[i], m_bz[i]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    // Edge offset (0 = sampling edge) of the first pulse on ch; -1 if none within maxn edges.
    task automatic measure(input int ch, input bit rise, input int maxn,
                           output int lat4, output int lat1, output int p4, output int b4);
        lat4 = -1; lat1 = -1; p4 = 0; b4 = 0;
        for (int n = 0; n < maxn; n++) begin
            step();
            if ((rise ? ri[0][ch] : fa[0][ch]) == 1'b1) begin
                p4++;
                if (lat4 < 0) lat4 = n;
            end
            if ((rise ? ri[1][ch] : fa[1][ch]) == 1'b1 && lat1 < 0) lat1 = n;
            if (bz[0][ch]) b4++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        int lat4, lat1, p4, b4, cnt;
        rst_n = 1'b0; en = 1'b1; clr_glitch = 1'b0; raw_in = 4'h0;
        model_reset();
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("reset stable", st[i], 0);
            chk("reset rise", ri[i], 0);
            chk("reset fall", fa[i], 0);
            chk("reset glitch", gl[i], 0);
            chk("reset busy", bz[i], 0);
        end
        rst_n = 1'b1;
        repeat (4) step();

        // clean rise on ch0
        raw_in[0] = 1'b1;
        measure(0, 1'b1, 12, lat4, lat1, p4, b4);
        chk("rise lat d4", lat4, 5);
        chk("rise lat d1", lat1, 2);
        chk("rise pulses", p4, 1);
        chk("rise busy cycles", b4, 3);

        // bounce on ch1 then clear
        cnt = 0;
        raw_in[1] = 1'b1;
        repeat (2) begin step(); cnt += int'(ri[0][1] | fa[0][1]); end
        raw_in[1] = 1'b0;
        repeat (8) begin step(); cnt += int'(ri[0][1] | fa[0][1]); end
        chk("bounce stable", st[0][1], 0);
        chk("bounce pulses", cnt, 0);
        chk("bounce glitch", gl[0][1], 1);
        clr_glitch = 1'b1;
        step();
        clr_glitch = 1'b0;
        chk("glitch cleared", gl[0], 0);

        // fall on ch2
        raw_in[2] = 1'b1;
        repeat (10) step();
        raw_in[2] = 1'b0;
        measure(2, 1'b0, 12, lat4, lat1, p4, b4);
        chk("fall lat d4", lat4, 5);
        chk("fall lat d1", lat1, 2);
        chk("fall pulses", p4, 1);

        // enable dropped exactly on the accept edge of ch3
        raw_in[3] = 1'b1;
        repeat (5) step();
        chk("en pending busy", bz[0][3], 1);
        en = 1'b0;
        step();
        chk("en hold stable", st[0][3], 0);
        chk("en no pulse", ri[0][3], 0);
        en = 1'b1;
        measure(3, 1'b1, 10, lat4, lat1, p4, b4);
        chk("en resume lat", lat4, 3);
        chk("en resume pulses", p4, 1);

        // all channels together
        raw_in = 4'h0;
        repeat (10) step();
        raw_in = 4'hF;
        cnt = 0;
        repeat (10) begin step(); if (ri[0] == 4'hF) cnt++; end
        chk("parallel rise", cnt, 1);

        // reset while every channel is mid-check
        raw_in = 4'h0;
        repeat (10) step();
        raw_in = 4'hF;
        repeat (3) step();
        chk("pre-reset busy", bz[0], 4'hF);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("async rst stable", st[0], 0);
        chk("async rst rise", ri[0], 0);
        chk("async rst glitch", gl[0], 0);
        chk("async rst busy", bz[0], 0);
        chk("async rst stable d1", st[1], 0);
        raw_in = 4'h0;
        repeat (2) step();
        rst_n = 1'b1;
        cnt = 0;
        repeat (10) begin step(); if ((ri[0] | fa[0] | ri[1] | fa[1]) != 4'h0) cnt++; end
        chk("post reset pulses", cnt, 0);

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < 4; c++)
                if ($urandom_range(0, 5) == 0) raw_in[c] = ~raw_in[c];
            en         = ($urandom_range(0, 39) != 0);
            clr_glitch = ($urandom_range(0, 29) == 0);
            rst_n      = ($urandom_range(0, 799) != 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
